// File: rtl/pcie_status_writeback.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pcie_status_writeback
//
// Config/status writeback engine for the PCIe control path. Each of NUM_SRC
// request sources raises a pending flag. Servicing a source means:
//    1. wait for the data path to release egress, take a ping-pong FIFO half,
//    2. copy min(REG_COUNT, fifo size) status words into that FIFO half,
//    3. issue one MWr32 to the host status address,
//    4. strobe an MSI tagged with the source index.
// A SEND that never finishes is aborted after TIMEOUT cycles. The source is
// then re-queued and no interrupt is raised for that attempt.
//
// Ports
//    clk, rst              clock, asynchronous active-high reset
//    i_cmd_rst_stb         in-band synchronous reset (same effect as rst)
//    i_req_stb             per-source request strobes, bit 0 highest priority
//    i_reg_data            flattened status words, word k = [32k+31:32k]
//    i_status_addr         host status buffer address
//    i_data_sm_idle        data path is not using egress
//    i_fifo_rdy/o_fifo_act ping-pong FIFO write ready / activate
//    i_fifo_size           ping-pong FIFO write size
//    o_fifo_stb/o_fifo_data ping-pong FIFO write strobe / data
//    o_cntrl_fifo_select   1 = egress reads the control FIFO
//    o_egress_*            egress TLP request (enable, command, address, count)
//    i_egress_finished     egress TLP done pulse
//    o_interrupt_stb/msi   one-cycle MSI request, value {0, source}
//    o_timeout_stb         one-cycle pulse on SEND abort
//    o_pending, o_busy     pending flags, engine not idle
// ---------------------------------------------------------------------------
module pcie_status_writeback #(
   parameter int unsigned REG_COUNT = 8,
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_cmd_rst_stb,
   input  logic [NUM_SRC-1:0]        i_req_stb,
   input  logic [32*REG_COUNT-1:0]   i_reg_data,
   input  logic [31:0]               i_status_addr,
   input  logic                      i_data_sm_idle,
   input  logic [1:0]                i_fifo_rdy,
   output logic [1:0]                o_fifo_act,
   input  logic [23:0]               i_fifo_size,
   output logic                      o_fifo_stb,
   output logic [31:0]               o_fifo_data,
   output logic                      o_cntrl_fifo_select,
   output logic                      o_egress_enable,
   input  logic                      i_egress_finished,
   output logic [7:0]                o_egress_tlp_command,
   output logic [31:0]               o_egress_tlp_address,
   output logic [9:0]                o_egress_dword_count,
   output logic                      o_interrupt_stb,
   output logic [7:0]                o_interrupt_msi_value,
   output logic                      o_timeout_stb,
   output logic [NUM_SRC-1:0]        o_pending,
   output logic                      o_busy
);

   localparam logic [7:0]  PCIE_MWR_32B = 8'h40;
   localparam int unsigned CNT_W = $clog2(REG_COUNT + 1);
   localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT);
   localparam int unsigned WORDS = 2 ** CNT_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_INT
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [SRC_W-1:0]   src_q, src_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [1:0]         act_q, act_d;
   logic               stb_q, stb_d;
   logic [31:0]        data_q, data_d;
   logic               sel_q, sel_d;
   logic               en_q, en_d;
   logic [7:0]         cmd_q, cmd_d;
   logic [31:0]        addr_q, addr_d;
   logic [9:0]         dcount_q, dcount_d;
   logic               int_stb_q, int_stb_d;
   logic [7:0]         msi_q, msi_d;
   logic               tmo_q, tmo_d;
   logic               busy_q, busy_d;

   logic [NUM_SRC-1:0] grant_mask;
   logic [SRC_W-1:0]   grant_idx;
   logic [NUM_SRC-1:0] src_mask;
   logic [NUM_SRC-1:0] pend_set;
   logic [NUM_SRC-1:0] pend_clr;

   // Word table padded to a power of two so the load counter indexes it
   // directly; padding entries are never reached because len <= REG_COUNT.
   logic [31:0] words [WORDS];

   for (genvar gk = 0; gk < WORDS; gk++) begin : g_word
      if (gk < REG_COUNT) begin : g_used
         assign words[gk] = i_reg_data[32*gk +: 32];
      end else begin : g_pad
         assign words[gk] = '0;
      end
   end

   // Lowest set pending bit wins; grant_mask isolates it as a one-hot.
   always_comb begin
      grant_mask = pend_q & (~pend_q + NUM_SRC'(1));
      grant_idx  = '0;
      src_mask   = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant_mask[i]) begin
            grant_idx = SRC_W'(i);
         end
         src_mask[i] = (src_q == SRC_W'(i));
      end
   end

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      tmr_d     = tmr_q;
      act_d     = act_q;
      data_d    = data_q;
      sel_d     = sel_q;
      en_d      = en_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      dcount_d  = dcount_q;
      msi_d     = msi_q;
      stb_d     = 1'b0;
      int_stb_d = 1'b0;
      tmo_d     = 1'b0;
      pend_set  = i_req_stb;
      pend_clr  = '0;

      case (state_q)
         ST_IDLE: begin
            if (|pend_q) begin
               src_d    = grant_idx;
               pend_clr = grant_mask;
               state_d  = ST_WAIT_IDLE;
            end
         end

         ST_WAIT_IDLE: begin
            if (i_data_sm_idle) begin
               sel_d = 1'b1;
               if ((i_fifo_rdy != 2'b00) && (act_q == 2'b00)) begin
                  act_d  = i_fifo_rdy[0] ? 2'b01 : 2'b10;
                  addr_d = i_status_addr;
                  len_d  = (i_fifo_size < 24'(REG_COUNT)) ?
                           i_fifo_size[CNT_W-1:0] : CNT_W'(REG_COUNT);
                  cnt_d  = '0;
                  state_d = ST_LOAD;
               end
            end
         end

         ST_LOAD: begin
            if (cnt_q != len_q) begin
               stb_d  = 1'b1;
               data_d = words[cnt_q];
               cnt_d  = cnt_q + CNT_W'(1);
            end else begin
               // Release cycle: FIFO half handed over, egress request raised.
               act_d    = 2'b00;
               en_d     = 1'b1;
               cmd_d    = PCIE_MWR_32B;
               dcount_d = 10'(len_q);
               tmr_d    = '0;
               state_d  = ST_SEND;
            end
         end

         ST_SEND: begin
            if (i_egress_finished) begin
               en_d      = 1'b0;
               cmd_d     = '0;
               int_stb_d = 1'b1;
               msi_d     = 8'(src_q);
               state_d   = ST_INT;
            end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
               // Abort: requeue the source so it is retried from IDLE.
               en_d     = 1'b0;
               cmd_d    = '0;
               tmo_d    = 1'b1;
               sel_d    = 1'b0;
               pend_set = pend_set | src_mask;
               state_d  = ST_IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         ST_INT: begin
            sel_d   = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Clear before set so a request landing on its own grant is kept.
      pend_d = (pend_q & ~pend_clr) | pend_set;
      busy_d = (state_d != ST_IDLE);

      if (i_cmd_rst_stb) begin
         state_d   = ST_IDLE;
         pend_d    = '0;
         src_d     = '0;
         cnt_d     = '0;
         len_d     = '0;
         tmr_d     = '0;
         act_d     = '0;
         stb_d     = 1'b0;
         data_d    = '0;
         sel_d     = 1'b0;
         en_d      = 1'b0;
         cmd_d     = '0;
         addr_d    = '0;
         dcount_d  = '0;
         int_stb_d = 1'b0;
         msi_d     = '0;
         tmo_d     = 1'b0;
         busy_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pend_q    <= '0;
         src_q     <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         tmr_q     <= '0;
         act_q     <= '0;
         stb_q     <= 1'b0;
         data_q    <= '0;
         sel_q     <= 1'b0;
         en_q      <= 1'b0;
         cmd_q     <= '0;
         addr_q    <= '0;
         dcount_q  <= '0;
         int_stb_q <= 1'b0;
         msi_q     <= '0;
         tmo_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         src_q     <= src_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         tmr_q     <= tmr_d;
         act_q     <= act_d;
         stb_q     <= stb_d;
         data_q    <= data_d;
         sel_q     <= sel_d;
         en_q      <= en_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         dcount_q  <= dcount_d;
         int_stb_q <= int_stb_d;
         msi_q     <= msi_d;
         tmo_q     <= tmo_d;
         busy_q    <= busy_d;
      end
   end

   assign o_fifo_act            = act_q;
   assign o_fifo_stb            = stb_q;
   assign o_fifo_data           = data_q;
   assign o_cntrl_fifo_select   = sel_q;
   assign o_egress_enable       = en_q;
   assign o_egress_tlp_command  = cmd_q;
   assign o_egress_tlp_address  = addr_q;
   assign o_egress_dword_count  = dcount_q;
   assign o_interrupt_stb       = int_stb_q;
   assign o_interrupt_msi_value = msi_q;
   assign o_timeout_stb         = tmo_q;
   assign o_pending             = pend_q;
   assign o_busy                = busy_q;

endmodule
